// File: rtl/usb_crc_tx_stream.sv
// USB packet serialiser: sends PID plus payload LSB-first over a valid/ready
// bit stream, then appends the complemented CRC5 (token) or CRC16 (data).
module usb_crc_tx_stream #(
  parameter int MAX_BITS = 100,
  parameter int PID_BITS = 8,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pkt_ready,
  input  logic [MAX_BITS-1:0] pkt_in,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic                crc16,
  input  logic                bs_ready,
  output logic                out_bit,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  // Handshake: a bit moves on every cycle with out_valid && bs_ready; while
  // out_valid is high and bs_ready low, out_bit and all internal state hold.

  localparam logic [LEN_W-1:0] PID_L = LEN_W'(PID_BITS);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t              state;
  logic [MAX_BITS-1:0] sr;
  logic [LEN_W-1:0]    len_q;
  logic                mode_q;
  logic [15:0]         crc_q;
  logic [LEN_W-1:0]    cnt;
  logic [4:0]          flush;

  logic                xfer;
  logic [LEN_W-1:0]    load_len;
  logic [15:0]         crc_next;
  logic [4:0]          flush_last;
  logic [3:0]          crc_idx;

  assign xfer       = out_valid && bs_ready;
  assign flush_last = mode_q ? 5'd15 : 5'd4;
  assign crc_idx    = mode_q ? (4'd15 - flush[3:0]) : (4'd4 - flush[3:0]);

  always_comb begin
    load_len = pkt_len;
    if (pkt_len < PID_L) begin
      load_len = PID_L;
    end else if (pkt_len > MAX_L) begin
      load_len = MAX_L;
    end
  end

  // CRC5 lives in crc_q[4:0] with the upper bits kept at zero.
  always_comb begin
    crc_next = crc_q;
    if (mode_q) begin
      crc_next = {crc_q[14:0], 1'b0} ^ ((sr[0] ^ crc_q[15]) ? 16'h8005 : 16'h0000);
    end else begin
      crc_next = {11'b0, crc_q[3:0], 1'b0} ^ ((sr[0] ^ crc_q[4]) ? 16'h0005 : 16'h0000);
    end
  end

  always_comb begin
    out_bit = 1'b0;
    case (state)
      S_PID, S_DATA: out_bit = sr[0];
      S_CRC:         out_bit = ~crc_q[crc_idx];
      default:       out_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      crc_q     <= '0;
      cnt       <= '0;
      flush     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_ready) begin
            sr        <= pkt_in;
            len_q     <= load_len;
            mode_q    <= crc16;
            crc_q     <= crc16 ? 16'hFFFF : 16'h001F;
            cnt       <= '0;
            flush     <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_PID;
          end
        end
        S_PID: begin
          if (xfer) begin
            sr  <= sr >> 1;
            cnt <= cnt + 1'b1;
            if (cnt == PID_L - 1'b1) begin
              state <= (len_q > PID_L) ? S_DATA : S_CRC;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            crc_q <= crc_next;
            sr    <= sr >> 1;
            cnt   <= cnt + 1'b1;
            if (cnt == len_q - 1'b1) begin
              state <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (xfer) begin
            flush <= flush + 1'b1;
            if (flush == flush_last) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_crc_tx_stream.sv
// Directed vector bench for usb_crc_tx_stream: CRC5/CRC16 packets, clamps,
// backpressure, mid-packet input changes and reset during the CRC field.
module tb_usb_crc_tx_stream;

  localparam int MAX_BITS = 100;
  localparam int PID_BITS = 8;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);
  localparam int TIMEOUT  = 2000;

  logic                clock;
  logic                reset_n;
  logic                pkt_ready;
  logic [MAX_BITS-1:0] pkt_in;
  logic [LEN_W-1:0]    pkt_len;
  logic                crc16;
  logic                bs_ready;
  logic                out_bit;
  logic                out_valid;
  logic                busy;
  logic                done;

  typedef struct {
    logic [MAX_BITS-1:0] pkt;
    logic [LEN_W-1:0]    len;
    logic                mode;
    bit                  stall;
    bit                  disturb;
    bit                  hand;
    logic [15:0]         tail;
  } vec_t;

  logic exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[9];

  usb_crc_tx_stream #(.MAX_BITS(MAX_BITS), .PID_BITS(PID_BITS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pkt_ready (pkt_ready),
    .pkt_in    (pkt_in),
    .pkt_len   (pkt_len),
    .crc16     (crc16),
    .bs_ready  (bs_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int vec, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, vec, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [MAX_BITS-1:0] p, input int len, input logic mode,
                              input bit stall, input bit disturb, input bit hand,
                              input logic [15:0] tail);
    vec_t v;
    v.pkt = p; v.len = LEN_W'(len); v.mode = mode; v.stall = stall;
    v.disturb = disturb; v.hand = hand; v.tail = tail;
    return v;
  endfunction

  function automatic int clamp_len(input vec_t v);
    int l = int'(v.len);
    if (l < PID_BITS) l = PID_BITS;
    if (l > MAX_BITS) l = MAX_BITS;
    return l;
  endfunction

  // Reference stream: packet bits, then either a hand-computed CRC tail or
  // one computed bit-serially from the polynomial definition.
  task automatic build_exp(input vec_t v);
    int          lc = clamp_len(v);
    int          n  = v.mode ? 16 : 5;
    logic [15:0] r;
    logic        msb;
    exp_q.delete();
    for (int i = 0; i < lc; i++) exp_q.push_back(v.pkt[i]);
    if (v.hand) begin
      for (int i = 0; i < n; i++) exp_q.push_back(v.tail[i]);
    end else begin
      r = v.mode ? 16'hFFFF : 16'h001F;
      for (int i = PID_BITS; i < lc; i++) begin
        msb = v.mode ? r[15] : r[4];
        r = r << 1;
        if (v.pkt[i] ^ msb) r = r ^ (v.mode ? 16'h8005 : 16'h0005);
        if (!v.mode) r = r & 16'h001F;
      end
      for (int i = 0; i < n; i++) exp_q.push_back(~r[n-1-i]);
    end
  endtask

  task automatic load(input vec_t v);
    @(negedge clock);
    pkt_in = v.pkt; pkt_len = v.len; crc16 = v.mode; pkt_ready = 1'b1; bs_ready = 1'b0;
    @(negedge clock);
    pkt_ready = 1'b0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int   total, idx, cyc, hold, lc;
    bit   stalled, br, boundary;
    logic held;
    build_exp(v);
    total = exp_q.size();
    lc = clamp_len(v);
    load(v);
    check("load_busy", vi, busy, 1);
    idx = 0; cyc = 0; hold = 0; stalled = 0; held = 1'b0;
    while (idx < total && cyc < TIMEOUT) begin
      if (stalled) check("stall_hold", vi, out_bit, held);
      check("valid", vi, out_valid, 1);
      check("no_done", vi, done, 0);
      br = 1'b1;
      if (v.stall) begin
        boundary = (idx == PID_BITS - 1) || (idx == PID_BITS) || (idx == lc - 1) ||
                   (idx == lc) || (idx == total - 1);
        br = ($urandom_range(0, 99) >= 40);
        if (boundary && hold < 2) br = 1'b0;
      end
      bs_ready = br;
      if (br) begin
        check("bit", vi, out_bit, exp_q.pop_front());
        idx++; hold = 0; stalled = 0;
      end else begin
        held = out_bit; stalled = 1; hold++;
      end
      if (v.disturb && idx < total) begin
        pkt_ready = 1'b1; pkt_in = ~v.pkt; crc16 = ~v.mode;
        pkt_len = LEN_W'($urandom_range(0, 127));
      end else begin
        pkt_ready = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    if (cyc >= TIMEOUT) check("timeout", vi, 1, 0);
    if (!v.stall) check("packet_cycles", vi, cyc, total);
    check("done_pulse", vi, done, 1);
    check("done_valid", vi, out_valid, 0);
    check("done_busy", vi, busy, 1);
    check("done_bit", vi, out_bit, 0);
    @(negedge clock);
    check("idle_busy", vi, busy, 0);
    check("idle_done", vi, done, 0);
    @(negedge clock);
    check("single_pkt", vi, busy, 0);
  endtask

  initial begin
    logic [127:0] rnd;
    vec_t         rv;
    int           lc;

    reset_n = 1'b0; pkt_ready = 1'b0; pkt_in = '0; pkt_len = '0; crc16 = 1'b0; bs_ready = 1'b0;

    rnd = {$urandom, $urandom, $urandom, $urandom};
    // SETUP addr 0 endp 0: CRC5 field 0x02 goes out as 0,1,0,0,0
    vecs[0] = mk(100'h2D, 19, 1'b0, 0, 0, 1, 16'h0002);
    // Zero-length DATA0: complement of 0xFFFF is sixteen zeros
    vecs[1] = mk(100'hC3, 8, 1'b1, 0, 0, 1, 16'h0000);
    vecs[2] = mk(100'h2D, 19, 1'b0, 1, 0, 1, 16'h0002);
    vecs[3] = mk(100'h2D, 19, 1'b0, 0, 1, 1, 16'h0002);
    vecs[4] = mk(100'hFFA5, 3, 1'b0, 0, 0, 1, 16'h0000);
    vecs[5] = mk(rnd[MAX_BITS-1:0], MAX_BITS + 20, 1'b1, 0, 0, 0, 16'h0);
    vecs[6] = mk(100'h03020100_4B, 40, 1'b1, 1, 0, 0, 16'h0);
    vecs[7] = mk(100'h1_7A2B_69, 29, 1'b0, 1, 0, 0, 16'h0);
    vecs[8] = mk(100'h5A5A_DEAD_BEEF_D2, 56, 1'b1, 0, 1, 0, 16'h0);

    repeat (3) @(negedge clock);
    check("rst_valid", -1, out_valid, 0);
    check("rst_busy", -1, busy, 0);
    check("rst_done", -1, done, 0);
    check("rst_bit", -1, out_bit, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while the third CRC16 bit is on the wire
    rv = mk(100'hABCD_4B, 24, 1'b1, 0, 0, 0, 16'h0);
    lc = clamp_len(rv);
    load(rv);
    bs_ready = 1'b1;
    repeat (lc + 2) @(negedge clock);
    check("pre_rst_valid", 90, out_valid, 1);
    check("pre_rst_busy", 90, busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 90, out_valid, 0);
    check("rst_mid_busy", 90, busy, 0);
    check("rst_mid_done", 90, done, 0);
    check("rst_mid_bit", 90, out_bit, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst_hold_done", 90, done, 0);
    end
    reset_n = 1'b1;
    bs_ready = 1'b0;
    run_vec(91, mk(100'h1234_5678_9A_C3, 48, 1'b1, 0, 0, 0, 16'h0));
    run_vec(92, mk(100'h3_5A_69, 19, 1'b0, 1, 0, 0, 16'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_crc_tx_stream.md
# usb_crc_tx_stream

Serialises one USB packet (PID plus payload) onto a one-bit stream and appends the complemented CRC, either CRC5 for token packets or CRC16 for data packets, selected per packet. It sits between the protocol handler, which presents a parallel packet, and the bit-stuffer, which applies backpressure through a ready/valid handshake. It generalises the fixed-width CRC5-only serialiser with three additions: a parametrised packet width, a CRC5/CRC16 mode, and a true valid/ready transfer rule.

## Interface
- MAX_BITS, 100: width of `pkt_in`, which is also the largest packet length in bits (PID included).
- PID_BITS, 8: number of leading bits sent but excluded from the CRC.
- LEN_W, $clog2(MAX_BITS+1): width of `pkt_len`.
- clock  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pkt_ready  input  1  load strobe from the protocol handler; honoured only in IDLE.
- pkt_in  input  MAX_BITS  packet; bit 0 is transmitted first.
- pkt_len  input  LEN_W  total bits to send from `pkt_in`, PID included.
- crc16  input  1  mode: 1 = CRC16 (x^16+x^15+x^2+1), 0 = CRC5 (x^5+x^2+1).
- bs_ready  input  1  bit-stuffer accepts `out_bit` this cycle.
- out_bit  output  1  current serial bit.
- out_valid  output  1  `out_bit` is meaningful.
- busy  output  1  a packet is in flight (state is not IDLE).
- done  output  1  one-cycle pulse after the last CRC bit transfers.

## Operation
- A transfer occurs on any cycle with `out_valid && bs_ready`. With `out_valid=1 && bs_ready=0`:
  - `out_bit`, state, counters and CRC register hold.
- Load happens on `pkt_ready` in IDLE. These are captured:
  - `pkt_in` into the shift register;
  - `min(max(pkt_len, PID_BITS), MAX_BITS)` into `len_q`;
  - `crc16` into `mode_q`;
  - CRC register set to all ones (5 or 16 bits per `mode_q`);
  - bit counter cleared.
- `pkt_ready` while not in IDLE is ignored; no queueing.
- State PID: send bits 0..PID_BITS-1. The CRC does not update. After the PID_BITS-th transfer:
  - go to DATA if `len_q > PID_BITS`;
  - otherwise go to CRC.
- State DATA: each transfer of bit b does two things:
  - shifts the CRC register: fb = b ^ msb; reg = (reg<<1) ^ (fb ? POLY : 0);
  - advances the counter.
  - POLY is 5'h05 or 16'h8005.
  - After the transfer with counter = `len_q`-1, go to CRC.
- State CRC: transmit the complemented register, MSB of the register first.
  - Send 5 bits (mode 0) or 16 bits (mode 1).
  - The flush counter advances only on transfer.
  - After the last transfer, go to DONE.
- State DONE: one cycle with `done=1` and `out_valid=0`, then IDLE.
- `out_bit` comes from the shift register LSB in PID/DATA and from the selected complemented CRC bit in CRC. It is 0 in IDLE/DONE.
- Counters are LEN_W bits for packet bits and 5 bits for the flush index. No wrap is possible because lengths are clamped.

## Timing
- Reset value of all outputs is 0; state is IDLE; all registers are cleared.
- Reset mid-packet aborts immediately with no `done` pulse.
- Latency: `pkt_ready` sampled at edge N gives `out_valid=1` with bit 0 during cycle N+1.
- With `bs_ready` held at 1, the packet occupies exactly `len_q` + (5 or 16) consecutive valid cycles, followed by 1 DONE cycle.
- `busy` rises the cycle after load and falls when DONE exits.
- A new `pkt_ready` is accepted in the first IDLE cycle after DONE. The minimum gap between packets is 1 cycle (DONE) plus the load edge.
- `bs_ready` changes take effect the same cycle; there is no skid. Stalls may occur at any bit, including PID→DATA, DATA→CRC and the last CRC bit.
- `pkt_len` < PID_BITS is treated as PID_BITS. `pkt_len` > MAX_BITS is treated as MAX_BITS.

## Test plan
- SETUP token, CRC5 mode:
  - Stimulus: `pkt_in` bytes 0x2D then 11 zero bits, `pkt_len`=19, `bs_ready`=1.
  - Required wire sequence after the PID and 11 zeros: 0,1,0,0,0 (the field value 0x02 sent LSB of the field first).
  - Then `done` pulses at cycle 1+19+5.
- Zero-length DATA0, CRC16 mode:
  - Stimulus: PID 0xC3, `pkt_len`=8.
  - Required: 8 PID bits, then 16 zero bits (the complement of 0xFFFF), then `done`.
- Backpressure:
  - Stimulus: same as the SETUP token case, with `bs_ready` toggled pseudo-randomly, including stalls at the PID→DATA boundary, the DATA→CRC boundary and the final CRC bit.
  - Required: the accepted bit sequence is identical to the no-stall run, and `out_bit` is stable throughout every stall.
- Mode and length capture:
  - Stimulus: change `crc16`, `pkt_len` and `pkt_in` mid-packet; assert `pkt_ready` while `busy`.
  - Required: output is unaffected, and exactly one packet is sent.
- Clamp:
  - Stimulus: `pkt_len`=3. Required: behaves as `pkt_len`=8.
  - Stimulus: `pkt_len`=MAX_BITS+20. Required: sends MAX_BITS bits plus the CRC.
- Reset mid-CRC:
  - Stimulus: assert `reset_n`=0 during the third CRC16 bit.
  - Required: all outputs are 0 immediately with no `done`. The next packet after reset is bit-exact against a software reference model.
